prog_sequencer: RTL
===================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter NUM_PROGS, default 3: number of programs run per start.
REQ-002 Parameter PROG1_ADDR, default 0; PROG2_ADDR, default 219; PROG3_ADDR, default 220: 10-bit program start addresses.
REQ-003 Parameter TIMEOUT, default 16'hFFFF: RUN-cycle limit per program.
REQ-004 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-005 init_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle request to run all programs.
REQ-007 abort  input  1  return to IDLE.
REQ-008 halt  input  1  core reports current program finished.
REQ-009 rd_sel  input  2  program index for the cycle-count readout.
REQ-010 core_init  output  1  holds the fetch unit and core in init.
REQ-011 pc_load  output  1  loads pc_load_addr into the PC this cycle.
REQ-012 pc_load_addr  output  10  start address of the current program.
REQ-013 prog_id  output  2  index of the current program (0-based).
REQ-014 busy  output  1  high in LOAD, RUN and DRAIN.
REQ-015 done  output  1  all programs completed; held until the next start, abort or reset.
REQ-016 timeout_flags  output  3  bit i set if program i hit TIMEOUT.
REQ-017 rd_cycles  output  16  latched RUN-cycle count of program rd_sel.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, RUN, DRAIN and DONE.
REQ-019 IDLE: core_init=1, busy=0; start SHALL go to LOAD with prog_id=0, clear timeout_flags and clear all latched counts.
REQ-020 LOAD SHALL last exactly 1 cycle: pc_load=1, pc_load_addr=start address of prog_id, core_init=1, cycle counter cleared; next state RUN.
REQ-021 pc_load SHALL be 0 in every state except LOAD; pc_load_addr SHALL always show the address of the current prog_id.
REQ-022 RUN: core_init=0; the 16-bit cycle counter SHALL increment by 1 each RUN cycle, counting the first RUN cycle as 1.
REQ-023 halt SHALL be sampled only in RUN; halt=1 -> DRAIN.
REQ-024 In RUN, if the counter equals TIMEOUT and halt=0, set timeout_flags[prog_id] and go to DRAIN; halt=1 in the same cycle wins and sets no flag.
REQ-025 DRAIN SHALL last 1 cycle: core_init=1; latch the counter into count[prog_id]; go to LOAD with prog_id+1, or to DONE if prog_id==NUM_PROGS-1.
REQ-026 DONE: done=1, core_init=1, busy=0; start -> LOAD with prog_id=0 and done cleared; done=0 in all other states.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 abort SHALL force IDLE on the next edge from any state, taking priority over start, halt and timeout; prog_id SHALL return to 0, with no count latched and no flag set that cycle.
REQ-029 rd_cycles SHALL be combinational from count[rd_sel]; it SHALL be 0 when rd_sel >= NUM_PROGS.
REQ-030 Total latency per program SHALL be RUN cycles + 2 (LOAD + DRAIN).

Reset
REQ-031 When init_n=0 at a posedge: state=IDLE, prog_id=0, counter=0, all counts=0, timeout_flags=0, done=0, busy=0, pc_load=0, core_init=1.
REQ-032 Reset SHALL override abort, start and halt, including a reset that arrives mid-RUN.

Structure
REQ-033 The state enum, the address width (10) and the count width (16) SHALL live in the shared package cpu_pkg.
REQ-034 The cycle counter with its TIMEOUT compare SHALL be a single sub-module, run_timer; everything else stays in prog_sequencer.

Verification
REQ-035 Reset, then start, with halt asserted after 5 RUN cycles for each program -> pc_load_addr 0, 219, 220 in turn; rd_cycles=5 for each; done=1 after the third DRAIN.
REQ-036 TIMEOUT=8, program 1 never halts -> timeout_flags=3'b010; rd_cycles[1]=8; sequencer proceeds to program 2.
REQ-037 halt and timeout in the same cycle (TIMEOUT=4, halt on RUN cycle 4) -> flag clear, count=4.
REQ-038 abort during RUN of program 1 -> IDLE next cycle, core_init=1, prog_id=0, done=0; a later start restarts at address 0.
REQ-039 start pulsed during RUN -> ignored; start in DONE -> LOAD prog 0 and done drops the next cycle.
REQ-040 init_n=0 mid-RUN -> all outputs at reset values on the next edge; rd_sel=3 -> rd_cycles=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and widths for the program sequencer and its run timer.
//   ADDR_W      : program-counter address width
//   CNT_W       : RUN-cycle counter width
//   seq_state_t : sequencer FSM states
package cpu_pkg;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/run_timer.sv
// RUN-cycle counter with timeout compare.
//   CLK      : clock
//   init_n   : synchronous active-low reset
//   clr      : clear the counter (asserted in LOAD)
//   en       : count this cycle (asserted in RUN)
//   cnt      : completed RUN cycles so far
//   at_limit : the current RUN cycle is number TIMEOUT
module run_timer
    import cpu_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF
) (
    input  logic             CLK,
    input  logic             init_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit
);

    logic [CNT_W-1:0] cnt_inc;

    // cnt holds completed cycles, so the cycle in progress is cnt+1;
    // this makes the first RUN cycle count as 1 for the compare.
    assign cnt_inc  = cnt + CNT_W'(1);
    assign at_limit = en && (cnt_inc == TIMEOUT);

    always_ff @(posedge CLK) begin
        if (!init_n || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt_inc;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Runs NUM_PROGS programs back to back on start: LOAD the PC, RUN until
// halt or timeout, DRAIN to latch the cycle count, then the next program.
//   CLK           : clock
//   init_n        : synchronous active-low reset
//   start         : run all programs (ignored while busy)
//   abort         : return to IDLE
//   halt          : core finished the current program
//   rd_sel        : program index for rd_cycles
//   core_init     : hold fetch unit / core in init
//   pc_load       : load pc_load_addr into PC this cycle
//   pc_load_addr  : start address of the current program
//   prog_id       : current program index
//   busy          : in LOAD, RUN or DRAIN
//   done          : all programs completed
//   timeout_flags : bit i set if program i timed out
//   rd_cycles     : latched RUN-cycle count of program rd_sel
module prog_sequencer
    import cpu_pkg::*;
#(
    parameter int                NUM_PROGS  = 3,
    parameter logic [ADDR_W-1:0] PROG1_ADDR = 10'd0,
    parameter logic [ADDR_W-1:0] PROG2_ADDR = 10'd219,
    parameter logic [ADDR_W-1:0] PROG3_ADDR = 10'd220,
    parameter logic [CNT_W-1:0]  TIMEOUT    = 16'hFFFF
) (
    input  logic              CLK,
    input  logic              init_n,
    input  logic              start,
    input  logic              abort,
    input  logic              halt,
    input  logic [1:0]        rd_sel,
    output logic              core_init,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_addr,
    output logic [1:0]        prog_id,
    output logic              busy,
    output logic              done,
    output logic [2:0]        timeout_flags,
    output logic [CNT_W-1:0]  rd_cycles
);

    localparam logic [1:0] LAST_ID = 2'(NUM_PROGS - 1);

    seq_state_t             state;
    logic [3:0][CNT_W-1:0]  count;
    logic [CNT_W-1:0]       run_cnt;
    logic                   at_limit;
    logic                   tmr_clr;
    logic                   tmr_en;

    assign tmr_clr = (state == ST_LOAD);
    assign tmr_en  = (state == ST_RUN);

    run_timer #(.TIMEOUT(TIMEOUT)) u_run_timer (
        .CLK      (CLK),
        .init_n   (init_n),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .cnt      (run_cnt),
        .at_limit (at_limit)
    );

    always_comb begin
        case (prog_id)
            2'd0:    pc_load_addr = PROG1_ADDR;
            2'd1:    pc_load_addr = PROG2_ADDR;
            default: pc_load_addr = PROG3_ADDR;
        endcase
    end

    // Unused program slots read back as zero.
    assign rd_cycles = ({1'b0, rd_sel} < 3'(NUM_PROGS)) ? count[rd_sel] : '0;

    always_ff @(posedge CLK) begin
        if (!init_n) begin
            state         <= ST_IDLE;
            prog_id       <= '0;
            count         <= '0;
            timeout_flags <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
            pc_load       <= 1'b0;
            core_init     <= 1'b1;
        end else if (abort) begin
            // Leaves counts and flags alone: nothing is latched this cycle.
            state     <= ST_IDLE;
            prog_id   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            pc_load   <= 1'b0;
            core_init <= 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state         <= ST_LOAD;
                        prog_id       <= '0;
                        count         <= '0;
                        timeout_flags <= '0;
                        done          <= 1'b0;
                        busy          <= 1'b1;
                        pc_load       <= 1'b1;
                        core_init     <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state     <= ST_RUN;
                    pc_load   <= 1'b0;
                    core_init <= 1'b0;
                end
                ST_RUN: begin
                    // halt wins over a timeout landing on the same cycle.
                    if (halt || at_limit) begin
                        state     <= ST_DRAIN;
                        core_init <= 1'b1;
                        if (!halt) begin
                            timeout_flags <= timeout_flags | (3'b001 << prog_id);
                        end
                    end
                end
                ST_DRAIN: begin
                    count[prog_id] <= run_cnt;
                    if (prog_id == LAST_ID) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state   <= ST_LOAD;
                        prog_id <= prog_id + 2'd1;
                        pc_load <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
